// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the SRAM arbiter: controller state encoding and
// address-width derivation.
package sram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Address width for a given depth; a depth of 1 still needs a 1-bit address.
  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/response bus between NREQ requesters and the SRAM arbiter.
// Per-requester fields are flattened: requester i sits at [i*W +: W].
interface sram_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 11,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i.
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);
  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PW'((int'(ptr_i) + off) % NREQ);
      if (!found && valid_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
endmodule

// File: rtl/sram_arbiter_sram.sv
// Single-port block SRAM with a registered read port; the array has no reset.
module sram_arbiter_sram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NREQ requesters.
// Zero-fills the SRAM after reset (CLEAR) before accepting requests (RUN).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 2048,
  parameter int NREQ           = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam int AW = aw_of(DEPTH);
  localparam int PW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]            arb_valid;
  logic [NREQ-1:0]            gnt;
  logic [PW-1:0]              gnt_idx;
  logic                       xfer;
  logic [NREQ-1:0][AW-1:0]    addr_v;
  logic [NREQ-1:0][WIDTH-1:0] wdata_v;
  logic                       sram_we;
  logic [AW-1:0]              sram_addr;
  logic [WIDTH-1:0]           sram_wdata;
  logic [WIDTH-1:0]           sram_rdata;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_v[i]  = bus.req_addr[i*AW +: AW];
    assign wdata_v[i] = bus.req_wdata[i*WIDTH +: WIDTH];
  end

  // Requests are invisible to the arbiter until the clear has finished.
  assign arb_valid = (state_q == ST_RUN) ? bus.req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .valid_i (arb_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

  assign xfer = |gnt;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    case (state_q)
      ST_CLEAR: begin
        sram_we   = 1'b1;
        sram_addr = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Idle cycles fall through to a harmless read of address 0.
        if (xfer) begin
          sram_we    = bus.req_we[gnt_idx];
          sram_addr  = addr_v[gnt_idx];
          sram_wdata = wdata_v[gnt_idx];
          rr_ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (!bus.req_we[gnt_idx]) rsp_valid_d = gnt;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  sram_arbiter_sram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk     (clk),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .rdata_o (sram_rdata)
  );

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = sram_rdata;
  assign bus.init_done = (state_q == ST_RUN);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid_q));
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: reset/clear timing, a cycle table of arbitration
// vectors, reset corner sequences, a randomized run against a memory model.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_nc = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.WIDTH(8), .AW(4), .NREQ(2)) bus ();
  sram_arbiter_if #(.WIDTH(8), .AW(4), .NREQ(2)) busn ();

  sram_arbiter #(.WIDTH(8), .DEPTH(16), .NREQ(2), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  sram_arbiter #(.WIDTH(8), .DEPTH(16), .NREQ(2), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst(rst_nc), .bus(busn));

  typedef struct {
    logic [1:0] v, we;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] rdy, rsp;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] v, we, input logic [3:0] a0, a1,
                              input logic [7:0] d0, d1, input logic [1:0] rdy, rsp,
                              input logic [7:0] rd);
    vec_t t;
    t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.rdy = rdy; t.rsp = rsp; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, we, input logic [3:0] a0, a1, input logic [7:0] d0, d1);
    bus.req_valid = v; bus.req_we = we; bus.req_addr = {a1, a0}; bus.req_wdata = {d1, d0};
  endtask

  task automatic drive_n(input logic [1:0] v, we, input logic [3:0] a0, input logic [7:0] d0);
    busn.req_valid = v; busn.req_we = we; busn.req_addr = {4'h0, a0}; busn.req_wdata = {8'h00, d0};
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called in the first cycle after rst falls; requests are held during the clear.
  task automatic wait_init(input string nm);
    int got;
    got = -1;
    drive(2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    chk({nm, "_rst_rsp"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_rst_init"}, 32'(bus.init_done), 32'd0);
    chk({nm, "_rst_rdy"}, 32'(bus.req_ready), 32'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.init_done) begin
        got = c;
        break;
      end
      chk({nm, "_clr_rdy"}, 32'(bus.req_ready), 32'd0);
    end
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    chk({nm, "_init_lat"}, 32'(got), 32'd16);
  endtask

  logic [7:0] mm [16];
  int         ptr, g, rr;
  logic [1:0] prsp, pv, pwe, exp_rdy;
  logic [7:0] prd;
  logic [3:0] pa [2];
  logic [7:0] pd [2];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    drive_n(2'b00, 2'b00, 4'h0, 8'h00);
    repeat (2) @(posedge clk);
    #1;

    // Reset, clear, then read every address from requester 0
    pulse_rst();
    wait_init("t1");
    for (int a = 0; a <= 16; a++) begin
      if (a < 16) drive(2'b01, 2'b00, 4'(a), 4'h0, 8'h00, 8'h00);
      else        drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
      @(negedge clk);
      if (a < 16) chk("t1_rdy", 32'(bus.req_ready), 32'd1);
      if (a > 0) begin
        chk("t1_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rdata", 32'(bus.rsp_rdata), 32'd0);
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of the clear restarts it
    pulse_rst();
    repeat (7) begin @(posedge clk); #1; end
    pulse_rst();
    wait_init("t5a");

    // Cycle table: RAW, req1-only run, alternation under contention
    tbl.push_back(mk(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00));
    tbl.push_back(mk(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00));
    tbl.push_back(mk(2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h5C, 2'b10, 2'b01, 8'hA5));
    tbl.push_back(mk(2'b01, 2'b01, 4'd1, 4'd0, 8'h3E, 8'h00, 2'b01, 2'b00, 8'h00));
    tbl.push_back(mk(2'b10, 2'b00, 4'd0, 4'd2, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(2'b10, 2'b00, 4'd0, 4'd2, 8'h00, 8'h00, 2'b10, 2'b10, 8'h5C));
    tbl.push_back(mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 2'b10, 8'h5C));
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0)
        tbl.push_back(mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 2'b01, 8'h3E));
      else
        tbl.push_back(mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 2'b10, 8'h5C));
    end
    tbl.push_back(mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b10, 8'h5C));
    tbl.push_back(mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rspv", i), 32'(bus.rsp_valid), 32'(tbl[i].rsp));
      if (tbl[i].rsp != 2'b00)
        chk($sformatf("tbl%0d_rdata", i), 32'(bus.rsp_rdata), 32'(tbl[i].rd));
      @(posedge clk); #1;
    end

    // Reset right after an accepted read drops the in-flight response
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5b_rdy", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5b_inflight", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5b_dropped", 32'(bus.rsp_valid), 32'd0);
    chk("t5b_rdy_clear", 32'(bus.req_ready), 32'd0);
    wait_init("t5b");

    // Randomized traffic against a memory/round-robin model
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    ptr = 0; prsp = 2'b00; prd = 8'h00; pv = 2'b00; pwe = 2'b00;
    pa[0] = 4'h0; pa[1] = 4'h0; pd[0] = 8'h00; pd[1] = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 3) != 0) begin
          pv[r]  = 1'b1;
          pwe[r] = ($urandom_range(0, 2) == 0);
          pa[r]  = 4'($urandom_range(0, 15));
          pd[r]  = 8'($urandom);
        end
      end
      drive(pv, pwe, pa[0], pa[1], pd[0], pd[1]);
      @(negedge clk);
      g = -1;
      for (int k = 0; k < 2; k++) begin
        rr = (ptr + k) % 2;
        if (g < 0 && pv[rr]) g = rr;
      end
      exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
      chk("rnd_rdy", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rnd_rspv", 32'(bus.rsp_valid), 32'(prsp));
      if (prsp != 2'b00) chk("rnd_rdata", 32'(bus.rsp_rdata), 32'(prd));
      prsp = 2'b00;
      if (g >= 0) begin
        if (pwe[g]) mm[pa[g]] = pd[g];
        else begin
          prsp = 2'(1 << g);
          prd  = mm[pa[g]];
        end
        ptr   = (g + 1) % 2;
        pv[g] = 1'b0;
      end
      @(posedge clk); #1;
    end
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rnd_tail_rspv", 32'(bus.rsp_valid), 32'(prsp));
    if (prsp != 2'b00) chk("rnd_tail_rdata", 32'(bus.rsp_rdata), 32'(prd));
    @(posedge clk); #1;

    // No-clear variant: RUN straight out of reset
    rst_nc = 1'b1;
    @(posedge clk); #1;
    rst_nc = 1'b0;
    drive_n(2'b01, 2'b00, 4'd5, 8'h00);
    @(negedge clk);
    chk("t6_init", 32'(busn.init_done), 32'd1);
    chk("t6_rdy", 32'(busn.req_ready), 32'd1);
    chk("t6_rsp0", 32'(busn.rsp_valid), 32'd0);
    @(posedge clk); #1;
    drive_n(2'b01, 2'b01, 4'd5, 8'h77);
    @(negedge clk);
    chk("t6_rsp1", 32'(busn.rsp_valid), 32'd1);
    chk("t6_wr_rdy", 32'(busn.req_ready), 32'd1);
    @(posedge clk); #1;
    drive_n(2'b01, 2'b00, 4'd5, 8'h00);
    @(negedge clk);
    chk("t6_wr_norsp", 32'(busn.rsp_valid), 32'd0);
    @(posedge clk); #1;
    drive_n(2'b00, 2'b00, 4'd0, 8'h00);
    @(negedge clk);
    chk("t6_rd_rsp", 32'(busn.rsp_valid), 32'd1);
    chk("t6_rd_data", 32'(busn.rsp_rdata), 32'h77);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
